// File: rtl/joy_db15_scan.sv
// Serial reader for the DB15 joystick adapter (two 74HC165-style chains).
// Produces per-player active-high button words and a frame_done strobe.
`timescale 1ns/1ps
module joy_db15_scan #(
  parameter int CLK_DIV    = 16,
  parameter int FRAME_BITS = 24,
  parameter int GAP_TICKS  = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        joy_data,
  output logic        joy_clk,
  output logic        joy_load,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_done
);

  localparam int P  = FRAME_BITS / 2;
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = $clog2(FRAME_BITS);
  localparam int GW = $clog2(GAP_TICKS + 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_SAMPLE,
    S_CLK,
    S_LATCH,
    S_GAP
  } state_t;

  state_t                state, state_n;
  logic [DW-1:0]         div;
  logic                  tick;
  logic [1:0]            sync;
  logic                  data_s;
  logic [BW-1:0]         bit_idx, bit_n;
  logic [GW-1:0]         gap, gap_n;
  logic [FRAME_BITS-1:0] sreg;
  logic                  cap, latch;
  logic [15:0]           j1_n, j2_n;

  assign tick   = (div == DW'(CLK_DIV - 1));
  assign data_s = sync[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div  <= '0;
      sync <= 2'b11;
    end else begin
      div  <= tick ? '0 : div + 1'b1;
      sync <= {sync[0], joy_data};
    end
  end

  always_comb begin
    state_n = state;
    bit_n   = bit_idx;
    gap_n   = gap;
    cap     = 1'b0;
    latch   = 1'b0;
    if (tick) begin
      unique case (state)
        S_LOAD: begin
          state_n = S_SAMPLE;
          bit_n   = '0;
        end
        S_SAMPLE: begin
          cap     = 1'b1;
          state_n = S_CLK;
        end
        S_CLK: begin
          if (bit_idx == BW'(FRAME_BITS - 1)) begin
            state_n = S_LATCH;
          end else begin
            bit_n   = bit_idx + 1'b1;
            state_n = S_SAMPLE;
          end
        end
        S_LATCH: begin
          latch   = 1'b1;
          gap_n   = '0;
          state_n = S_GAP;
        end
        S_GAP: begin
          if (gap == GW'(GAP_TICKS - 1)) begin
            state_n = S_LOAD;
          end else begin
            gap_n = gap + 1'b1;
          end
        end
        default: state_n = S_LOAD;
      endcase
    end
  end

  // Wire is active-low; upper bits beyond P stay zero.
  always_comb begin
    j1_n         = '0;
    j2_n         = '0;
    j1_n[P-1:0]  = ~sreg[P-1:0];
    j2_n[P-1:0]  = ~sreg[2*P-1:P];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_LOAD;
      bit_idx    <= '0;
      gap        <= '0;
      sreg       <= '1;
      joy_clk    <= 1'b0;
      joy_load   <= 1'b1;
      joystick1  <= '0;
      joystick2  <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      bit_idx    <= bit_n;
      gap        <= gap_n;
      // Line levels follow the next state, so they only move on tick edges.
      joy_clk    <= (state_n == S_CLK);
      joy_load   <= (state_n != S_LOAD);
      frame_done <= latch;
      if (cap) begin
        sreg[bit_idx] <= data_s;
      end
      if (latch) begin
        joystick1 <= j1_n;
        joystick2 <= j2_n;
      end
    end
  end

endmodule
